// File: rtl/b2s_pkg.sv
// Shared b2s timing defaults and type definitions, common to transmitter and receiver.
package b2s_pkg;
  localparam int START_MIN_D = 15;
  localparam int START_MAX_D = 25;
  localparam int ONE_MIN_D   = 5;
  localparam int ONE_MAX_D   = 15;
  localparam int ZERO_MIN_D  = 25;
  localparam int ZERO_MAX_D  = 35;
  localparam int TIMEOUT_D   = 60;

  typedef enum logic [1:0] {PK_BAD, PK_START, PK_ONE, PK_ZERO} pulse_kind_t;
  typedef enum logic {ST_IDLE, ST_DATA} rx_state_t;
endpackage

// File: rtl/b2s_pulse_meter.sv
// Synchronises the b2s line, flags edges and measures each low pulse.
// L holds the completed low width in the rise cycle; saturates at 2^CW-1.
module b2s_pulse_meter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  output logic          rise,
  output logic          fall,
  output logic [CW-1:0] L,
  output logic          line_hi
);
  logic sync1, sync2, edge_q;
  logic [CW-1:0] low_cnt;

  // Flops preset high so a released reset on an idle line sees no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      edge_q  <= 1'b1;
      low_cnt <= '0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      edge_q <= sync2;
      if (!sync2) begin
        if (fall)
          low_cnt <= CW'(1);
        else if (low_cnt != '1)
          low_cnt <= low_cnt + CW'(1);
      end
    end
  end

  assign fall    = edge_q & ~sync2;
  assign rise    = ~edge_q & sync2;
  assign line_hi = sync2;
  assign L       = low_cnt;
endmodule

// File: rtl/b2s_rx_param.sv
// b2s pulse-width receiver: decodes START/ONE/ZERO pulses into WIDTH-bit frames.
// dout/dout_valid and frame_err are registered, one cycle after the classifying rise.
module b2s_rx_param
  import b2s_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CW        = 6,
  parameter int START_MIN = START_MIN_D,
  parameter int START_MAX = START_MAX_D,
  parameter int ONE_MIN   = ONE_MIN_D,
  parameter int ONE_MAX   = ONE_MAX_D,
  parameter int ZERO_MIN  = ZERO_MIN_D,
  parameter int ZERO_MAX  = ZERO_MAX_D,
  parameter int TIMEOUT   = TIMEOUT_D,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b2s_din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int HW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic rise, fall, line_hi;
  logic [CW-1:0] L;
  logic [31:0] lw;
  pulse_kind_t kind;
  rx_state_t state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [HW-1:0] hi_cnt;
  logic [WIDTH-1:0] sr, sr_nxt, shifted, dout_nxt;
  logic vld_nxt, err_nxt, timeout;

  b2s_pulse_meter #(.CW(CW)) u_meter (
    .clk     (clk),
    .rst     (rst),
    .din     (b2s_din),
    .rise    (rise),
    .fall    (fall),
    .L       (L),
    .line_hi (line_hi)
  );

  // Window bounds are exclusive; the saturated width falls through to BAD.
  assign lw = 32'(L);
  always_comb begin
    kind = PK_BAD;
    if (L != '1) begin
      if (lw > 32'(START_MIN) && lw < 32'(START_MAX))     kind = PK_START;
      else if (lw > 32'(ONE_MIN) && lw < 32'(ONE_MAX))    kind = PK_ONE;
      else if (lw > 32'(ZERO_MIN) && lw < 32'(ZERO_MAX))  kind = PK_ZERO;
    end
  end

  always_comb begin
    shifted = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST)
        shifted[i] = (i == 0) ? (kind == PK_ONE) : sr[i-1];
      else
        shifted[i] = (i == WIDTH-1) ? (kind == PK_ONE) : sr[i+1];
    end
  end

  assign timeout = line_hi && (hi_cnt == HW'(TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    dout_nxt    = dout;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise && kind == PK_START) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
          sr_nxt      = '0;
        end
      end
      ST_DATA: begin
        if (rise) begin
          case (kind)
            PK_START: begin
              err_nxt     = 1'b1;
              bit_cnt_nxt = '0;
              sr_nxt      = '0;
            end
            PK_ONE, PK_ZERO: begin
              sr_nxt = shifted;
              if (bit_cnt == BW'(WIDTH - 1)) begin
                dout_nxt    = shifted;
                vld_nxt     = 1'b1;
                bit_cnt_nxt = '0;
                state_nxt   = ST_IDLE;
              end else begin
                bit_cnt_nxt = bit_cnt + BW'(1);
              end
            end
            default: begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          endcase
        end else if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      hi_cnt     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sr         <= sr_nxt;
      dout       <= dout_nxt;
      dout_valid <= vld_nxt;
      frame_err  <= err_nxt;
      if (!line_hi)
        hi_cnt <= '0;
      else if (hi_cnt != HW'(TIMEOUT - 1))
        hi_cnt <= hi_cnt + HW'(1);
    end
  end

  assign busy = (state == ST_DATA);
endmodule
